adder_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 32-bit Ladner-Fischer `adder` instance among NREQ requesters.
- Supports multi-word (wider than 32-bit) additions: a requester keeps the adder locked across words, and the carry is chained internally.
- The result is registered in a single output slot with a valid/ready handshake.
- Sits between the ALU-side requesters and the shared adder datapath.

---
 rtl/adder_sched_pkg.sv | 23 ++
 rtl/adder.sv | 55 +++++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/adder_rr_sched.sv | 170 +++++++++++++++++
 tb/tb_adder_rr_sched.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_sched_pkg.sv
// ---------------------------------------------------------------------------
// adder_sched_pkg
// Shared types and constants for the round-robin adder scheduler.
//   sched_state_t : scheduler state (IDLE = free to arbitrate, LOCKED = a
//                   multi-word operation owns the adder)
//   ADD_W         : datapath width of the shared adder
//   id_width()    : requester-ID width for a given requester count
// ---------------------------------------------------------------------------
package adder_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  localparam int ADD_W = 32;

  // At least one bit so a single-requester build still has a legal ID port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder
// 32-bit Ladner-Fischer (minimum-depth parallel prefix) adder, combinational.
//   a, b : operands
//   cin  : carry-in
//   sum  : a + b + cin, low 32 bits
//   cout : carry-out of bit 31
// ---------------------------------------------------------------------------
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0]      g0;
  logic [31:0]      p0;
  logic [5:0][31:0] g_lvl;
  logic [4:0][31:0] p_lvl;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Folding cin into bit 0's generate makes every prefix G[i:0] include it.
  assign g_lvl[0] = {g0[31:1], g0[0] | (p0[0] & cin)};
  assign p_lvl[0] = p0;

  // Level gl: bits in the upper half of each 2^(gl+1) block combine with the
  // top bit of the lower half, so after 5 levels g_lvl[5][i] = G[i:0].
  for (genvar gl = 0; gl < 5; gl++) begin : g_level
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      if (((gi >> gl) & 1) == 1) begin : g_op
        localparam int J = ((gi >> (gl + 1)) << (gl + 1)) + (1 << gl) - 1;
        assign g_lvl[gl+1][gi] = g_lvl[gl][gi] | (p_lvl[gl][gi] & g_lvl[gl][J]);
        if (gl < 4) begin : g_p
          assign p_lvl[gl+1][gi] = p_lvl[gl][gi] & p_lvl[gl][J];
        end
      end else begin : g_pass
        assign g_lvl[gl+1][gi] = g_lvl[gl][gi];
        if (gl < 4) begin : g_p
          assign p_lvl[gl+1][gi] = p_lvl[gl][gi];
        end
      end
    end
  end

  // Only part of the last propagate level feeds the final generate level.
  logic unused_p;
  assign unused_p = ^p_lvl[4];

  assign sum  = p0 ^ {g_lvl[5][30:0], cin};
  assign cout = g_lvl[5][31];

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at rr_ptr and wraps
// past NREQ-1 back to 0; the first requesting index wins.
//   req     : request vector
//   rr_ptr  : index with highest priority this cycle
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : encoded index of the grant (0 when nothing requests)
// ---------------------------------------------------------------------------
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]               req,
  input  logic [id_width(NREQ)-1:0]     rr_ptr,
  output logic [NREQ-1:0]               gnt,
  output logic [id_width(NREQ)-1:0]     gnt_idx
);

  localparam int IDW = id_width(NREQ);

  logic           found;
  logic [IDW:0]   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One spare bit so rr_ptr + k can exceed NREQ-1 before the wrap.
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IDW-1:0]]   = 1'b1;
        gnt_idx              = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// ---------------------------------------------------------------------------
// adder_rr_sched
// Shares one 32-bit adder among NREQ requesters with round-robin arbitration.
// A requester whose word has req_last=0 locks the adder; its next words use
// the carry chained from the previous word. Results go to a single registered
// slot with a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : per-requester word handshake
//   req_a, req_b      : packed operands, requester i at [i*W +: W]
//   req_cin           : carry-in for the first word of an operation
//   req_last          : final word of an operation
//   rsp_valid/ready   : result slot handshake
//   rsp_sum, rsp_cout : registered sum and carry-out of the word
//   rsp_id, rsp_last  : issuing requester and its last flag
// ---------------------------------------------------------------------------
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*W-1:0]             req_a,
  input  logic [NREQ*W-1:0]             req_b,
  input  logic [NREQ-1:0]               req_cin,
  input  logic [NREQ-1:0]               req_last,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [W-1:0]                  rsp_sum,
  output logic                          rsp_cout,
  output logic [id_width(NREQ)-1:0]     rsp_id,
  output logic                          rsp_last
);

  localparam int IDW = id_width(NREQ);

  if (W != ADD_W) begin : g_bad_width
    $error("adder_rr_sched: W must be 32");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("adder_rr_sched: NREQ must be 2..8");
  end

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             carry_q, carry_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_last_q, rsp_last_d;

  logic [W-1:0]     a_arr [NREQ];
  logic [W-1:0]     b_arr [NREQ];
  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic [NREQ-1:0]  owner_mask;
  logic [NREQ-1:0]  grant_mask;
  logic [IDW-1:0]   sel_idx;
  logic             slot_free;
  logic             accept;
  logic             add_cin;
  logic [W-1:0]     add_sum;
  logic             add_cout;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*W +: W];
    assign b_arr[gi] = req_b[gi*W +: W];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  adder u_adder (
    .a    (a_arr[sel_idx]),
    .b    (b_arr[sel_idx]),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Handshake side: depends only on registered state, req_valid, rsp_ready
  // (and rst, so nothing is accepted while reset is held).
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    slot_free           = !rsp_valid_q || rsp_ready;
    if (state_q == IDLE) begin
      sel_idx    = arb_idx;
      grant_mask = arb_gnt;
      add_cin    = req_cin[arb_idx];
    end else begin
      sel_idx    = owner_q;
      grant_mask = owner_mask & req_valid;
      add_cin    = carry_q;
    end
    req_ready = (slot_free && !rst) ? grant_mask : '0;
    accept    = |req_ready;
  end

  // Next-state: the slot is overwritten on acceptance (covers drain+fill in
  // one cycle); otherwise a drain only clears valid and payload holds.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    rsp_last_d  = rsp_last_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_id_d    = sel_idx;
      rsp_last_d  = req_last[sel_idx];
      carry_d     = add_cout;
      if (req_last[sel_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = (sel_idx == IDW'(NREQ-1)) ? '0 : sel_idx + IDW'(1);
      end else begin
        state_d = LOCKED;
        owner_d = sel_idx;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_sched
// Directed bench for adder_rr_sched: a table of single-word additions plus
// hand-written sequences for arbitration, chaining, backpressure, owner stall
// and reset in the middle of a chain.
// ---------------------------------------------------------------------------
module tb_adder_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [1:0]        rsp_id;
  logic              rsp_last;

  int n_checks = 0;
  int n_fail   = 0;

  adder_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic last);
    req_valid[i]     = v;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_cin[i]       = cin;
    req_last[i]      = last;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_last  = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] sum, input logic cout,
                         input int id, input logic last);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_sum"},   64'(rsp_sum),   64'(sum));
    chk({tag, "_cout"},  64'(rsp_cout),  64'(cout));
    chk({tag, "_id"},    64'(rsp_id),    64'(id));
    chk({tag, "_last"},  64'(rsp_last),  64'(last));
    $display("txn %s: id=%0d sum=0x%08h cout=%0d last=%0d", tag, rsp_id, rsp_sum, rsp_cout, rsp_last);
  endtask

  initial begin
    vecs[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vecs[2] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[5] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[6] = '{3, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7] = '{2, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 32'hDFAE_BFF0, 1'b0};
    vecs[8] = '{0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};

    // ---- reset state, with requests already pending ----
    rst       = 1'b1;
    rsp_ready = 1'b0;
    clr_all();
    req_valid = '1;
    settle();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_sum",   64'(rsp_sum),   64'(0));
    chk("rst_cout",  64'(rsp_cout),  64'(0));
    chk("rst_id",    64'(rsp_id),    64'(0));
    chk("rst_last",  64'(rsp_last),  64'(0));
    tick();
    rst = 1'b0;
    clr_all();
    rsp_ready = 1'b1;

    // ---- table of single-word operations ----
    for (int v = 0; v < 9; v++) begin
      clr_all();
      set_req(vecs[v].id, 1'b1, vecs[v].a, vecs[v].b, vecs[v].cin, 1'b1);
      settle();
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(1) << vecs[v].id);
      tick();
      chk_rsp($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cout, vecs[v].id, 1'b1);
    end
    clr_all();
    tick();
    chk("drain_valid", 64'(rsp_valid), 64'(0));

    // ---- round robin from a fresh pointer: 0,1,2,3,0 ----
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, 32'(i * 256), 32'(i), 1'b0, 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(1) << (k % 4));
      tick();
      chk_rsp($sformatf("rr%0d", k), 32'((k % 4) * 257), 1'b0, k % 4, 1'b1);
    end

    // ---- 64-bit chain from req 2 while req 1 waits ----
    rst = 1'b1;
    #1;
    rst = 1'b0;
    clr_all();
    set_req(1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b1);      // moves rr_ptr to 2
    settle();
    chk("prime_ready", 64'(req_ready), 64'h2);
    tick();
    chk_rsp("prime", 32'd11, 1'b0, 1, 1'b1);
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'd7, 32'd8, 1'b0, 1'b1);
    settle();
    chk("chain0_ready", 64'(req_ready), 64'h4);
    tick();
    chk_rsp("chain0", 32'h0, 1'b1, 2, 1'b0);
    set_req(2, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    chk("chain1_ready", 64'(req_ready), 64'h4);
    tick();
    chk_rsp("chain1", 32'h1, 1'b0, 2, 1'b1);
    set_req(2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("after_chain_ready", 64'(req_ready), 64'h2);
    tick();
    chk_rsp("after_chain", 32'd15, 1'b0, 1, 1'b1);

    // ---- backpressure: slot full, everything frozen for 5 cycles ----
    clr_all();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'h100, 32'h23, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'(0));
      tick();
      chk_rsp($sformatf("bp%0d", k), 32'd15, 1'b0, 1, 1'b1);
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_release_ready", 64'(req_ready), 64'h1);
    tick();
    chk_rsp("bp_release", 32'h123, 1'b0, 0, 1'b1);

    // ---- owner stall inside a lock ----
    clr_all();
    set_req(3, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    settle();
    chk("stall0_ready", 64'(req_ready), 64'h8);
    tick();
    chk_rsp("stall0", 32'h0, 1'b1, 3, 1'b0);
    set_req(3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_req(0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);
    set_req(1, 1'b1, 32'h2, 32'h2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("stall_wait%0d_ready", k), 64'(req_ready), 64'(0));
      tick();
      chk($sformatf("stall_wait%0d_valid", k), 64'(rsp_valid), 64'(0));
    end
    set_req(3, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);      // cin ignored: carry_q=1
    settle();
    chk("stall1_ready", 64'(req_ready), 64'h8);
    tick();
    chk_rsp("stall1", 32'h3, 1'b0, 3, 1'b1);

    // ---- reset in the middle of a chain with a pending result ----
    clr_all();
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    settle();
    chk("midrst0_ready", 64'(req_ready), 64'h4);
    tick();
    chk_rsp("midrst0", 32'h0, 1'b1, 2, 1'b0);
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'd2, 32'd3, 1'b0, 1'b1);
    set_req(3, 1'b1, 32'd9, 32'd9, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_sum",   64'(rsp_sum),   64'(0));
    rst = 1'b0;
    rsp_ready = 1'b1;
    settle();
    chk("postrst_ready", 64'(req_ready), 64'h2);
    tick();
    chk_rsp("postrst", 32'd5, 1'b0, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
